memory_region_decoder: RTL and testbench
========================================

# memory_region_decoder

Parametrised address-region decoder that sits between the core data port and the data memory, shared memory and MMIO blocks. It produces per-region enables combinationally from an address field and delays the read-mux select through a configurable pipeline aligned to memory read latency. It also flags unmapped or runtime-disabled accesses, with a sticky fault capture and a saturating fault counter.

## Interface
Parameters:
- ADDR_W, 32, width of the core address.
- SEL_LSB, 13, bit position of the lowest region-select address bit.
- SEL_W, 2, number of region-select address bits.
- NUM_REGIONS, 3, number of mapped regions. Range 1..2^SEL_W. Region index i maps to o_region_enable[i].
- READ_LATENCY, 1, cycles from read request to read data at the mux. Range 1..4.
- CNT_W, 8, width of the fault counter.

Ports:
- clk, in, 1, clock. Everything is on the rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- i_addr, in, ADDR_W, access address.
- i_req, in, 1, access valid this cycle.
- i_we, in, 1, access is a write. Ignored when i_req=0.
- i_region_mask, in, NUM_REGIONS, runtime region enable (1 = region accessible).
- i_fault_clear, in, 1, clears the sticky fault, the fault address and the fault counter.
- o_region_enable, out, NUM_REGIONS, one-hot or zero region enable. Combinational.
- o_readmem_mux_sel, out, SEL_W, region index of the read whose data returns this cycle.
- o_rd_valid, out, 1, read data returns this cycle.
- o_rd_fault, out, 1, the returning read was unmapped. The mux drives zero data.
- o_fault, out, 1, sticky fault flag.
- o_fault_addr, out, ADDR_W, address of the first fault since the last clear.
- o_fault_is_write, out, 1, direction of that captured fault.
- o_fault_count, out, CNT_W, saturating count of faults since the last clear.

## Operation
- idx = i_addr[SEL_LSB +: SEL_W].
- hit = i_req && idx < NUM_REGIONS && i_region_mask[idx].
- o_region_enable[i] = hit && idx == i. All zero when i_req=0.
- miss = i_req && !hit. A miss asserts no enable.
- Read pipeline is a shift register of depth READ_LATENCY. Each stage holds {valid, fault, sel}.
  - Stage 0 loads {i_req && !i_we, miss, idx} every cycle.
  - The last stage drives o_rd_valid, o_rd_fault and o_readmem_mux_sel.
- o_readmem_mux_sel holds its previous value whenever the last stage has valid=0. Only a valid entry updates it.
- o_rd_fault is qualified by valid. It is 0 whenever o_rd_valid=0.
- Fault capture on a miss (read or write):
  - If o_fault=0: set o_fault, capture i_addr into o_fault_addr and i_we into o_fault_is_write.
  - If o_fault=1: the capture registers keep the first fault.
  - o_fault_count increments on every miss and saturates at 2^CNT_W-1.
- i_fault_clear zeroes o_fault, o_fault_addr, o_fault_is_write and o_fault_count.
- Clear and miss in the same cycle: the clear applies first, then the miss is recorded. Result: o_fault=1, new address and direction captured, count=1.
- Writes never enter the read pipeline as valid entries.

## Timing
- o_region_enable has zero latency: it is combinational from i_addr, i_req and i_region_mask.
- Read request at cycle N: o_rd_valid=1 and the select appear at cycle N+READ_LATENCY. Back-to-back reads give back-to-back valids at full throughput.
- Fault registers update on the edge that ends the miss cycle and are visible at N+1.
- An i_region_mask change affects decode in the same cycle. Entries already in flight are unaffected.
- Reset (asynchronous assert, synchronous deassert handled upstream) sets:
  - every pipeline stage to zero;
  - o_readmem_mux_sel=0, o_rd_valid=0, o_rd_fault=0;
  - o_fault=0, o_fault_addr=0, o_fault_is_write=0, o_fault_count=0.
- Reset mid-flight discards all pending reads. No o_rd_valid follows.

## Test plan
- Defaults, mask=3'b111:
  - Reads to 0x0000, 0x2000 and 0x4000 on consecutive cycles give enables 001, 010, 100 in the same cycle.
  - o_rd_valid=1 on cycles N+1..N+3 with sel 0, 1, 2. o_fault stays 0.
- READ_LATENCY=3:
  - Read to 0x2000 at N, no request after it. o_rd_valid=1 and sel=1 only at N+3.
  - sel holds 1 afterwards while o_rd_valid=0.
- Unmapped read 0x6004 at N:
  - Enables 000.
  - At N+1: o_fault=1, o_fault_addr=0x6004, o_fault_is_write=0, count=1.
  - At N+READ_LATENCY: o_rd_valid=1, o_rd_fault=1.
- Mask=3'b101, write to 0x2010:
  - No enable and no o_rd_valid.
  - Fault captured with is_write=1.
  - A second fault to 0x6000 leaves addr=0x2010 and makes count=2.
- CNT_W=2, five misses:
  - Count sequence 1, 2, 3, 3, 3.
  - Then i_fault_clear together with a miss to 0x7000: o_fault=1, addr=0x7000, count=1.
- Reads at N and N+1, then reset_n low at N+1 for one cycle:
  - All outputs are 0 immediately and no o_rd_valid appears afterwards.

Source files
------------

// File: rtl/memory_region_decoder_if.sv
// memory_region_decoder_if
//   Bus bundle between the core data port and the region decoder.
//   master : core side, drives the access request and the fault clear, and
//            observes the decode, read-return and fault status signals.
//   slave  : decoder side, the mirror image of master.
//   Signals:
//     i_addr, i_req, i_we         access address, valid, write direction
//     i_region_mask               runtime per-region accessibility
//     i_fault_clear               clears the sticky fault state
//     o_region_enable             combinational one-hot region enable
//     o_readmem_mux_sel           read-data mux select for the returning read
//     o_rd_valid, o_rd_fault      read return strobe and unmapped flag
//     o_fault, o_fault_addr,
//     o_fault_is_write,
//     o_fault_count               sticky fault capture and saturating count
interface memory_region_decoder_if #(
   parameter int ADDR_W      = 32,
   parameter int SEL_W       = 2,
   parameter int NUM_REGIONS = 3,
   parameter int CNT_W       = 8
);
   logic [ADDR_W-1:0]      i_addr;
   logic                   i_req;
   logic                   i_we;
   logic [NUM_REGIONS-1:0] i_region_mask;
   logic                   i_fault_clear;
   logic [NUM_REGIONS-1:0] o_region_enable;
   logic [SEL_W-1:0]       o_readmem_mux_sel;
   logic                   o_rd_valid;
   logic                   o_rd_fault;
   logic                   o_fault;
   logic [ADDR_W-1:0]      o_fault_addr;
   logic                   o_fault_is_write;
   logic [CNT_W-1:0]       o_fault_count;

   modport master (
      output i_addr, i_req, i_we, i_region_mask, i_fault_clear,
      input  o_region_enable, o_readmem_mux_sel, o_rd_valid, o_rd_fault,
      input  o_fault, o_fault_addr, o_fault_is_write, o_fault_count
   );

   modport slave (
      input  i_addr, i_req, i_we, i_region_mask, i_fault_clear,
      output o_region_enable, o_readmem_mux_sel, o_rd_valid, o_rd_fault,
      output o_fault, o_fault_addr, o_fault_is_write, o_fault_count
   );
endinterface

// File: rtl/memory_region_decoder.sv
// memory_region_decoder
//   Decodes the region-select field of the core address into per-region
//   enables (combinational), carries the read-mux select through a pipeline
//   matched to the memory read latency, and records unmapped or masked
//   accesses in a sticky fault capture with a saturating counter.
//   Ports:
//     clk     : clock, rising edge
//     reset_n : asynchronous active-low reset
//     bus     : memory_region_decoder_if.slave (request in, decode/status out)
module memory_region_decoder #(
   parameter int ADDR_W       = 32,
   parameter int SEL_LSB      = 13,
   parameter int SEL_W        = 2,
   parameter int NUM_REGIONS  = 3,
   parameter int READ_LATENCY = 1,
   parameter int CNT_W        = 8
) (
   input logic                   clk,
   input logic                   reset_n,
   memory_region_decoder_if.slave bus
);

   localparam int              LAST        = READ_LATENCY - 1;
   localparam int              IDX_SPAN    = 2 ** SEL_W;
   localparam logic [SEL_W:0]  NUM_REG_EXT = (SEL_W + 1)'(NUM_REGIONS);

   // decode
   logic [SEL_W-1:0]       idx_s;
   logic [IDX_SPAN-1:0]    mask_pad_s;
   logic                   in_range_s;
   logic                   hit_s;
   logic                   miss_s;
   logic                   rd_req_s;
   logic [NUM_REGIONS-1:0] enable_s;

   // read pipeline: *_d_s is what each stage loads on the next edge
   logic [READ_LATENCY-1:0]            stage_valid_r;
   logic [READ_LATENCY-1:0]            stage_fault_r;
   logic [READ_LATENCY-1:0][SEL_W-1:0] stage_sel_r;
   logic [READ_LATENCY-1:0]            stage_valid_d_s;
   logic [READ_LATENCY-1:0]            stage_fault_d_s;
   logic [READ_LATENCY-1:0][SEL_W-1:0] stage_sel_d_s;
   logic [SEL_W-1:0]                   mux_sel_r;

   // fault capture
   logic              fault_r;
   logic [ADDR_W-1:0] fault_addr_r;
   logic              fault_is_write_r;
   logic [CNT_W-1:0]  fault_count_r;
   logic              fault_base_s;
   logic [ADDR_W-1:0] fault_addr_base_s;
   logic              fault_is_write_base_s;
   logic [CNT_W-1:0]  fault_count_base_s;
   logic              fault_d_s;
   logic [ADDR_W-1:0] fault_addr_d_s;
   logic              fault_is_write_d_s;
   logic [CNT_W-1:0]  fault_count_d_s;

   // Region decode: index, range/mask qualification, one-hot enable.
   always_comb begin
      idx_s      = bus.i_addr[SEL_LSB +: SEL_W];
      // Unmapped index slots read as masked-off so the mask lookup never
      // needs an out-of-range guard.
      mask_pad_s = '0;
      mask_pad_s[NUM_REGIONS-1:0] = bus.i_region_mask;
      in_range_s = ({1'b0, idx_s} < NUM_REG_EXT);
      hit_s      = bus.i_req && in_range_s && mask_pad_s[idx_s];
      miss_s     = bus.i_req && !hit_s;
      rd_req_s   = bus.i_req && !bus.i_we;
      enable_s   = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         enable_s[i] = hit_s && (idx_s == SEL_W'(i));
      end
   end

   assign bus.o_region_enable = enable_s;

   // Next value of each pipeline stage: stage 0 takes the current access,
   // later stages shift from their predecessor.
   always_comb begin
      stage_valid_d_s    = '0;
      stage_fault_d_s    = '0;
      stage_sel_d_s      = '0;
      stage_valid_d_s[0] = rd_req_s;
      stage_fault_d_s[0] = miss_s;
      stage_sel_d_s[0]   = idx_s;
      for (int k = 1; k < READ_LATENCY; k++) begin
         stage_valid_d_s[k] = stage_valid_r[k-1];
         stage_fault_d_s[k] = stage_fault_r[k-1];
         stage_sel_d_s[k]   = stage_sel_r[k-1];
      end
   end

   // Read pipeline shift register and the held read-mux select.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stage_valid_r <= '0;
         stage_fault_r <= '0;
         stage_sel_r   <= '0;
         mux_sel_r     <= '0;
      end else begin
         stage_valid_r <= stage_valid_d_s;
         stage_fault_r <= stage_fault_d_s;
         stage_sel_r   <= stage_sel_d_s;
         // The select only follows valid returns so the mux stays put
         // between reads.
         if (stage_valid_d_s[LAST]) begin
            mux_sel_r <= stage_sel_d_s[LAST];
         end else begin
            mux_sel_r <= mux_sel_r;
         end
      end
   end

   assign bus.o_rd_valid        = stage_valid_r[LAST];
   assign bus.o_rd_fault        = stage_valid_r[LAST] & stage_fault_r[LAST];
   assign bus.o_readmem_mux_sel = mux_sel_r;

   // Fault next state: apply the clear first, then record this cycle's miss
   // on top of the cleared state.
   always_comb begin
      if (bus.i_fault_clear) begin
         fault_base_s          = 1'b0;
         fault_addr_base_s     = '0;
         fault_is_write_base_s = 1'b0;
         fault_count_base_s    = '0;
      end else begin
         fault_base_s          = fault_r;
         fault_addr_base_s     = fault_addr_r;
         fault_is_write_base_s = fault_is_write_r;
         fault_count_base_s    = fault_count_r;
      end

      fault_d_s          = fault_base_s;
      fault_addr_d_s     = fault_addr_base_s;
      fault_is_write_d_s = fault_is_write_base_s;
      fault_count_d_s    = fault_count_base_s;

      if (miss_s) begin
         // Only the first fault since the last clear is captured.
         if (!fault_base_s) begin
            fault_d_s          = 1'b1;
            fault_addr_d_s     = bus.i_addr;
            fault_is_write_d_s = bus.i_we;
         end else begin
            fault_d_s          = fault_base_s;
         end
         if (fault_count_base_s == {CNT_W{1'b1}}) begin
            fault_count_d_s = fault_count_base_s;
         end else begin
            fault_count_d_s = fault_count_base_s + CNT_W'(1);
         end
      end else begin
         fault_d_s = fault_base_s;
      end
   end

   // Fault capture registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fault_r          <= 1'b0;
         fault_addr_r     <= '0;
         fault_is_write_r <= 1'b0;
         fault_count_r    <= '0;
      end else begin
         fault_r          <= fault_d_s;
         fault_addr_r     <= fault_addr_d_s;
         fault_is_write_r <= fault_is_write_d_s;
         fault_count_r    <= fault_count_d_s;
      end
   end

   assign bus.o_fault          = fault_r;
   assign bus.o_fault_addr     = fault_addr_r;
   assign bus.o_fault_is_write = fault_is_write_r;
   assign bus.o_fault_count    = fault_count_r;

endmodule

// File: tb/tb_memory_region_decoder.sv
// tb_memory_region_decoder
//   Two decoder instances share one stimulus stream: instance a uses the
//   default parameters (read latency 1, 8-bit counter), instance b uses read
//   latency 3 and a 2-bit counter. A reference model keeps a per-cycle log of
//   issued accesses and a simple fault record per instance; expected outputs
//   are derived from that log.
module tb_memory_region_decoder;

   localparam int ADDR_W = 32;
   localparam int CW_A   = 8;
   localparam int CW_B   = 2;
   localparam int RL_A   = 1;
   localparam int RL_B   = 3;
   localparam int MAXC   = 4096;

   logic clk;
   logic reset_n;

   memory_region_decoder_if #(.ADDR_W(ADDR_W), .SEL_W(2), .NUM_REGIONS(3), .CNT_W(CW_A)) bus_a ();
   memory_region_decoder_if #(.ADDR_W(ADDR_W), .SEL_W(2), .NUM_REGIONS(3), .CNT_W(CW_B)) bus_b ();

   memory_region_decoder #(
      .ADDR_W(ADDR_W), .SEL_LSB(13), .SEL_W(2), .NUM_REGIONS(3),
      .READ_LATENCY(RL_A), .CNT_W(CW_A)
   ) dut_a (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_a)
   );

   memory_region_decoder #(
      .ADDR_W(ADDR_W), .SEL_LSB(13), .SEL_W(2), .NUM_REGIONS(3),
      .READ_LATENCY(RL_B), .CNT_W(CW_B)
   ) dut_b (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Per-cycle access log: read issued, miss, region index.
   bit h_rd   [0:MAXC-1];
   bit h_miss [0:MAXC-1];
   int h_idx  [0:MAXC-1];
   int cyc;

   // Per-instance model state.
   int          lat  [2] = '{RL_A, RL_B};
   int          cmax [2] = '{(1 << CW_A) - 1, (1 << CW_B) - 1};
   bit          m_fault [2];
   logic [31:0] m_addr  [2];
   bit          m_wr    [2];
   int          m_cnt   [2];
   int          m_sel   [2];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [31:0] addr, input bit req, input bit we,
                        input logic [2:0] mask, input bit clr);
      bus_a.i_addr = addr; bus_a.i_req = req; bus_a.i_we = we;
      bus_a.i_region_mask = mask; bus_a.i_fault_clear = clr;
      bus_b.i_addr = addr; bus_b.i_req = req; bus_b.i_we = we;
      bus_b.i_region_mask = mask; bus_b.i_fault_clear = clr;
   endtask

   task automatic model_clear_all();
      for (int i = 0; i < MAXC; i++) begin
         h_rd[i] = 1'b0;
         h_miss[i] = 1'b0;
         h_idx[i] = 0;
      end
      for (int k = 0; k < 2; k++) begin
         m_fault[k] = 1'b0; m_addr[k] = 32'h0; m_wr[k] = 1'b0;
         m_cnt[k] = 0; m_sel[k] = 0;
      end
   endtask

   // Compare every registered output of both instances against the model.
   task automatic check_outputs();
      for (int k = 0; k < 2; k++) begin
         int    issue;
         bit    ev, ef;
         logic  gv, gf, gfl, gwr;
         logic [31:0] ga;
         logic [7:0]  gcnt;
         logic [1:0]  gsel;
         string s;
         s = (k == 0) ? "a" : "b";
         issue = cyc - lat[k];
         ev = (issue >= 0) ? h_rd[issue] : 1'b0;
         ef = ev && h_miss[issue];
         if (ev) m_sel[k] = h_idx[issue];
         if (k == 0) begin
            gv = bus_a.o_rd_valid; gf = bus_a.o_rd_fault; gsel = bus_a.o_readmem_mux_sel;
            gfl = bus_a.o_fault; ga = bus_a.o_fault_addr; gwr = bus_a.o_fault_is_write;
            gcnt = bus_a.o_fault_count;
         end else begin
            gv = bus_b.o_rd_valid; gf = bus_b.o_rd_fault; gsel = bus_b.o_readmem_mux_sel;
            gfl = bus_b.o_fault; ga = bus_b.o_fault_addr; gwr = bus_b.o_fault_is_write;
            gcnt = {6'b0, bus_b.o_fault_count};
         end
         check_eq({"rd_valid_", s}, 64'(gv), 64'(ev));
         check_eq({"rd_fault_", s}, 64'(gf), 64'(ef));
         check_eq({"mux_sel_", s}, 64'(gsel), 64'(m_sel[k]));
         check_eq({"fault_", s}, 64'(gfl), 64'(m_fault[k]));
         check_eq({"fault_addr_", s}, 64'(ga), 64'(m_addr[k]));
         check_eq({"fault_wr_", s}, 64'(gwr), 64'(m_wr[k]));
         check_eq({"fault_cnt_", s}, 64'(gcnt), 64'(m_cnt[k]));
      end
   endtask

   // One access cycle: drive, check the combinational enables mid-cycle,
   // advance the model across the edge, then check registered outputs.
   task automatic step(input logic [31:0] addr, input bit req, input bit we,
                       input logic [2:0] mask, input bit clr);
      int idx;
      bit hit, miss;
      logic [2:0] en_exp;
      drive(addr, req, we, mask, clr);
      @(negedge clk);
      idx    = int'((addr >> 13) & 32'd3);
      hit    = req && (idx < 3) && mask[idx];
      miss   = req && !hit;
      en_exp = hit ? 3'(1 << idx) : 3'b000;
      check_eq("enable_a", 64'(bus_a.o_region_enable), 64'(en_exp));
      check_eq("enable_b", 64'(bus_b.o_region_enable), 64'(en_exp));
      h_rd[cyc]   = req && !we;
      h_miss[cyc] = miss;
      h_idx[cyc]  = idx;
      for (int k = 0; k < 2; k++) begin
         if (clr) begin
            m_fault[k] = 1'b0; m_addr[k] = 32'h0; m_wr[k] = 1'b0; m_cnt[k] = 0;
         end
         if (miss) begin
            if (!m_fault[k]) begin
               m_fault[k] = 1'b1; m_addr[k] = addr; m_wr[k] = we;
            end
            if (m_cnt[k] < cmax[k]) m_cnt[k]++;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(32'h0, 1'b0, 1'b0, 3'b111, 1'b0);
   endtask

   // Asynchronous reset in the middle of a cycle: outputs drop at once and
   // every in-flight read is discarded.
   task automatic do_reset();
      drive(32'h0, 1'b0, 1'b0, 3'b111, 1'b0);
      reset_n = 1'b0;
      #1;
      model_clear_all();
      check_outputs();
      @(posedge clk);
      #1;
      cyc++;
      check_outputs();
      reset_n = 1'b1;
   endtask

   initial begin
      cyc = 0;
      model_clear_all();
      drive(32'h0, 1'b0, 1'b0, 3'b111, 1'b0);
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      reset_n = 1'b1;

      // Consecutive reads to each mapped region.
      step(32'h0000_0000, 1'b1, 1'b0, 3'b111, 1'b0);
      step(32'h0000_2000, 1'b1, 1'b0, 3'b111, 1'b0);
      step(32'h0000_4000, 1'b1, 1'b0, 3'b111, 1'b0);
      idle(4);
      check_eq("dir_no_fault", 64'(bus_a.o_fault), 64'd0);

      // Lone read: select must hold after the valid drops.
      step(32'h0000_2000, 1'b1, 1'b0, 3'b111, 1'b0);
      idle(5);
      check_eq("dir_sel_hold_b", 64'(bus_b.o_readmem_mux_sel), 64'd1);

      // Unmapped read.
      step(32'h0000_6004, 1'b1, 1'b0, 3'b111, 1'b0);
      check_eq("dir_unmapped_addr", 64'(bus_a.o_fault_addr), 64'h6004);
      check_eq("dir_unmapped_cnt", 64'(bus_a.o_fault_count), 64'd1);
      idle(3);

      // Masked write, then a second fault keeps the first address.
      step(32'h0, 1'b0, 1'b0, 3'b111, 1'b1);
      step(32'h0000_2010, 1'b1, 1'b1, 3'b101, 1'b0);
      check_eq("dir_masked_wr", 64'(bus_a.o_fault_is_write), 64'd1);
      step(32'h0000_6000, 1'b1, 1'b1, 3'b101, 1'b0);
      check_eq("dir_first_addr", 64'(bus_a.o_fault_addr), 64'h2010);
      check_eq("dir_cnt2", 64'(bus_a.o_fault_count), 64'd2);
      idle(3);

      // Saturation of the 2-bit counter, then clear together with a miss.
      step(32'h0, 1'b0, 1'b0, 3'b111, 1'b1);
      for (int i = 0; i < 5; i++) begin
         int exp_cnt;
         exp_cnt = (i < 3) ? i + 1 : 3;
         step(32'h0000_6000, 1'b1, 1'b0, 3'b111, 1'b0);
         check_eq("dir_sat_b", 64'(bus_b.o_fault_count), 64'(exp_cnt));
      end
      step(32'h0000_7000, 1'b1, 1'b0, 3'b111, 1'b1);
      check_eq("dir_clr_miss_addr", 64'(bus_b.o_fault_addr), 64'h7000);
      check_eq("dir_clr_miss_cnt", 64'(bus_b.o_fault_count), 64'd1);
      idle(4);

      // Reset with reads in flight.
      step(32'h0000_0000, 1'b1, 1'b0, 3'b111, 1'b0);
      step(32'h0000_2000, 1'b1, 1'b0, 3'b111, 1'b0);
      do_reset();
      idle(5);

      // Randomized traffic with occasional clears and one reset.
      for (int i = 0; i < 600; i++) begin
         logic [31:0] a;
         bit req, we, clr;
         a   = $urandom;
         req = ($urandom_range(0, 9) < 8);
         we  = ($urandom_range(0, 9) < 3);
         clr = ($urandom_range(0, 19) == 0);
         step(a, req, we, 3'($urandom_range(0, 7)), clr);
         if (i == 300) do_reset();
      end
      idle(4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
